dual_port_ram_pipe: RTL and testbench
=====================================

// Module: dual_port_ram_pipe
// PURPOSE
//  Single-clock simple dual-port RAM (1 write port, 1 read port) for NoC/NoP buffering.
//  Adds per-byte write enables, a configurable read pipeline, and a defined read/write collision policy.
//  Also adds a hardware clear engine that zeroes the array, on request or automatically after reset.
//  Drop-in storage for packet buffers and routing tables that need a deterministic initial state.
// PARAMETERS
//  DATA_WIDTH   32  word width in bits; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8
//  ADDR_WIDTH   4   address bits; DEPTH = 2**ADDR_WIDTH words
//  READ_LATENCY 1   1 or 2 clk from rd_en to rd_data/rd_valid; 2 adds an output register stage
//  WRITE_FIRST  1   same-address collision: 1 = read returns merged new data, 0 = read returns old data
//  INIT_CLEAR   1   1 = start a clear sweep automatically when rst deasserts; 0 = idle after reset
// PORTS
//  clk       in   1           single clock, all logic on posedge
//  rst       in   1           asynchronous, active-high reset
//  wr_en     in   1           write request
//  wr_addr   in   ADDR_WIDTH  write address
//  wr_be     in   BE_WIDTH    byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data   in   DATA_WIDTH  write data
//  wr_ready  out  1           write accepted when wr_en & wr_ready; equals ~clr_busy
//  rd_en     in   1           read request
//  rd_addr   in   ADDR_WIDTH  read address
//  rd_data   out  DATA_WIDTH  read data, registered
//  rd_valid  out  1           one-cycle pulse per accepted read, aligned with rd_data
//  clr_req   in   1           request a full-array zero sweep
//  clr_busy  out  1           high while the clear sweep runs
// BEHAVIOUR
//  Reset values (async, while rst=1):
//   rd_data=0, rd_valid=0, pipeline stages=0, clr_ptr=0.
//   state=CLEAR if INIT_CLEAR else IDLE; clr_busy=INIT_CLEAR.
//   Memory array is not reset.
//  Write: on posedge with wr_en & wr_ready, mem[wr_addr] byte i <= wr_data byte i for each wr_be[i]=1.
//   wr_be=0 is accepted and changes nothing. wr_en while clr_busy is dropped; requester must hold it.
//  Read: accepted on posedge with rd_en & ~clr_busy. rd_en during clr_busy is dropped (no rd_valid).
//   Accept at edge N -> rd_data/rd_valid updated at edge N+READ_LATENCY.
//   Full throughput: one read per cycle, back-to-back.
//   rd_data holds its last value when no read completes; rd_valid=0 in those cycles.
//  Collision: read and write accepted on the same edge with rd_addr==wr_addr.
//   WRITE_FIRST=1: read returns old word with enabled bytes replaced by wr_data.
//   WRITE_FIRST=0: read returns the pre-write word.
//   Different addresses: independent, no interaction.
//  Clear FSM, states IDLE and CLEAR:
//   IDLE -> CLEAR when clr_req=1; clr_ptr<=0.
//   CLEAR: each cycle mem[clr_ptr]<=0 and clr_ptr++. The cycle with clr_ptr==DEPTH-1 writes, then -> IDLE.
//   The sweep lasts exactly DEPTH cycles. clr_busy = (state==CLEAR), registered.
//   clr_req while in CLEAR is ignored; no restart, no queueing.
//   Reads launched before CLEAR entry finish normally through the pipeline.
//  Reset mid-operation: sweep aborts, read pipeline flushed, in-flight reads produce no rd_valid.
//   On release, INIT_CLEAR=1 restarts a full sweep from address 0.
//  Address arithmetic: clr_ptr is ADDR_WIDTH bits, no wrap beyond one pass.
// TESTING
//  1 INIT_CLEAR=1, release rst:
//    clr_busy=1 for exactly 16 cycles, wr_ready=0 throughout.
//    Then reading addr 0..15 returns 0x00000000 with rd_valid 1 cycle (LAT=1) or 2 cycles (LAT=2) after rd_en.
//  2 Write 0xAABBCCDD to addr 3 (be=F), then 0x11223344 to addr 3 with be=4'b0101:
//    read addr 3 -> 0xAA22CC44.
//  3 Same-edge write 0xDEADBEEF (be=F) and read, both addr 5, which holds 0x0:
//    WRITE_FIRST=1 -> rd_data=0xDEADBEEF; WRITE_FIRST=0 -> rd_data=0x0.
//  4 LAT=2, rd_en on 4 consecutive cycles to addrs 0..3 preloaded with 1..4:
//    rd_valid high 4 consecutive cycles, data 1,2,3,4 in order.
//  5 clr_req during idle with data present:
//    16-cycle busy; rd_en and wr_en during busy are dropped (no rd_valid, no write).
//    clr_req pulsed mid-sweep does not extend it. Afterwards every address reads 0.
//  6 Assert rst at cycle 7 of a sweep and with a read in flight:
//    rd_valid stays 0, outputs 0; after release a fresh 16-cycle sweep runs from addr 0.

Source files
------------

// File: rtl/dual_port_ram_pipe.sv
// ---------------------------------------------------------------------------
// dual_port_ram_pipe
// Single-clock simple dual-port RAM (one write port, one read port) with
// per-byte write enables, a 1- or 2-stage registered read path, a fixed
// same-address collision policy and a hardware clear engine that zeroes the
// whole array on request or automatically after reset.
//
// Ports
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset
//   wr_en     write request, accepted when wr_en & wr_ready
//   wr_addr   write address
//   wr_be     byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data   write data
//   wr_ready  low while the clear sweep runs
//   rd_en     read request, accepted when rd_en & ~clr_busy
//   rd_addr   read address
//   rd_data   registered read data, holds between reads
//   rd_valid  one-cycle pulse aligned with rd_data
//   clr_req   start a full-array zero sweep (ignored while sweeping)
//   clr_busy  high while the sweep runs
// ---------------------------------------------------------------------------
module dual_port_ram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    clr_req,
    output logic                    clr_busy
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_vld_q;

    // clr_busy comes straight off the state register, so it is registered.
    assign clr_busy = (state_q == CLEAR);
    assign wr_ready = ~clr_busy;
    assign wr_acc   = wr_en & ~clr_busy;
    assign rd_acc   = rd_en & ~clr_busy;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_CLEAR != 0) state_q <= CLEAR;
            else                 state_q <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                // Pointer wraps back to 0 on the last word, leaving it ready
                // for the next sweep; the state change ends this one.
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- storage (not reset) ----------------
    // The sweep and the write port never overlap: writes are blocked while
    // clr_busy is high.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read word with the collision policy applied: in write-first mode the
    // enabled bytes of a same-edge, same-address write are forwarded.
    always_comb begin
        rd_word = mem_q[rd_addr];
        if ((WRITE_FIRST != 0) && wr_acc && (wr_addr == rd_addr)) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Data registers only load when a read passes through, so the output
    // holds its last value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) s1_data_q <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic                  s2_vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld_q  <= 1'b0;
                    s2_data_q <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) s2_data_q <= s1_data_q;
                end
            end
            assign rd_data  = s2_data_q;
            assign rd_valid = s2_vld_q;
        end else begin : g_lat1
            assign rd_data  = s1_data_q;
            assign rd_valid = s1_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
module tb_dual_port_ram_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        clr_req = 1'b0;

    // a: LAT=1 write-first, b: LAT=2 read-first; both see the same stimulus
    logic        wr_ready_a, rd_valid_a, clr_busy_a;
    logic [31:0] rd_data_a;
    logic        wr_ready_b, rd_valid_b, clr_busy_b;
    logic [31:0] rd_data_b;

    int n_pass = 0;
    int n_total = 0;
    int cnt;
    int bad;

    always #5 clk = ~clk;

    dual_port_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                         .WRITE_FIRST(1), .INIT_CLEAR(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .wr_ready(wr_ready_a), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .clr_req(clr_req), .clr_busy(clr_busy_a));

    dual_port_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
                         .WRITE_FIRST(0), .INIT_CLEAR(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .wr_ready(wr_ready_b), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .clr_req(clr_req), .clr_busy(clr_busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; wr_be = '0;
    endtask

    task automatic write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Count busy cycles of a sweep already in progress; wr_ready must stay low.
    task automatic count_sweep(input string tag);
        cnt = 0; bad = 0;
        while (clr_busy_a && cnt < 40) begin
            if (wr_ready_a || wr_ready_b || !clr_busy_b) bad++;
            cnt++;
            step();
        end
        chk({tag, "_busy_cycles"}, cnt, 16);
        chk({tag, "_ready_low"}, bad, 0);
        chk({tag, "_busy_done"}, {clr_busy_a, clr_busy_b, wr_ready_a, wr_ready_b}, 4'b0011);
    endtask

    // Back-to-back reads of every address, expecting zero from both copies.
    task automatic read_all_zero(input string tag);
        bad = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin rd_en = 1'b1; rd_addr = 4'(i); end
            else rd_en = 1'b0;
            step();
            if (i < 16 && !(rd_valid_a === 1'b1 && rd_data_a === 32'h0)) bad++;
            if (i >= 1 && !(rd_valid_b === 1'b1 && rd_data_b === 32'h0)) bad++;
        end
        chk({tag, "_bad_reads"}, bad, 0);
        step();
        chk({tag, "_valid_off"}, {rd_valid_a, rd_valid_b}, 2'b00);
    endtask

    initial begin
        // ---- reset state ----
        step(); step();
        chk("rst_outputs_a", {rd_valid_a, clr_busy_a, wr_ready_a}, 3'b010);
        chk("rst_outputs_b", {rd_valid_b, clr_busy_b, wr_ready_b}, 3'b010);
        chk("rst_data_a", rd_data_a, 32'h0);
        chk("rst_data_b", rd_data_b, 32'h0);

        // ---- 1: automatic sweep after reset, then all zero ----
        rst = 1'b0;
        count_sweep("init");
        read_all_zero("init");

        // ---- 2: byte enables ----
        write(4'd3, 4'hF, 32'hAABBCCDD);
        write(4'd3, 4'b0101, 32'h11223344);
        write(4'd3, 4'b0000, 32'hFFFFFFFF);
        rd_en = 1'b1; rd_addr = 4'd3; step(); rd_en = 1'b0;
        chk("be_merge_a", {31'h0, rd_valid_a}, 1);
        chk("be_merge_data_a", rd_data_a, 32'hAA22CC44);
        chk("be_merge_b_pending", {31'h0, rd_valid_b}, 0);
        step();
        chk("be_merge_a_pulse", {31'h0, rd_valid_a}, 0);
        chk("be_merge_a_hold", rd_data_a, 32'hAA22CC44);
        chk("be_merge_data_b", {rd_valid_b, rd_data_b[30:0]}, {1'b1, 31'h2A22CC44});

        // ---- 3: same-address collision ----
        wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        rd_en = 1'b1; rd_addr = 4'd5;
        step(); idle_inputs();
        chk("coll_wf_a", rd_data_a, 32'hDEADBEEF);
        step();
        chk("coll_rf_b", {31'h0, rd_valid_b}, 1);
        chk("coll_rf_data_b", rd_data_b, 32'h0);
        rd_en = 1'b1; rd_addr = 4'd5; step(); rd_en = 1'b0; step();
        chk("coll_after_b", rd_data_b, 32'hDEADBEEF);

        // ---- 4: back-to-back reads ----
        for (int i = 0; i < 4; i++) write(4'(i), 4'hF, 32'(i + 1));
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin rd_en = 1'b1; rd_addr = 4'(i); end
            else rd_en = 1'b0;
            step();
            if (i < 4) chk($sformatf("b2b_a_%0d", i), {rd_valid_a, rd_data_a}, {1'b1, 32'(i + 1)});
            else chk($sformatf("b2b_a_idle_%0d", i), {31'h0, rd_valid_a}, 0);
            if (i >= 1 && i <= 4)
                chk($sformatf("b2b_b_%0d", i), {rd_valid_b, rd_data_b}, {1'b1, 32'(i)});
            else
                chk($sformatf("b2b_b_idle_%0d", i), {31'h0, rd_valid_b}, 0);
        end
        chk("b2b_b_hold", rd_data_b, 32'd4);

        // ---- 5: requested sweep, dropped traffic, ignored mid-sweep request ----
        clr_req = 1'b1; step(); clr_req = 1'b0;
        cnt = 0; bad = 0;
        while (clr_busy_a && cnt < 40) begin
            cnt++;
            wr_en = 1'b1; wr_addr = 4'd7; wr_be = 4'hF; wr_data = 32'h12345678;
            rd_en = 1'b1; rd_addr = 4'(cnt);
            clr_req = (cnt == 8);
            step();
            if (rd_valid_a || rd_valid_b) bad++;
        end
        idle_inputs();
        chk("clr_busy_cycles", cnt, 16);
        chk("clr_no_rd_valid", bad, 0);
        step();
        chk("clr_tail_valid", {rd_valid_a, rd_valid_b, clr_busy_a}, 3'b000);
        read_all_zero("clr");

        // ---- 6a: reset in the middle of a sweep ----
        clr_req = 1'b1; step(); clr_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_sweep_busy", {clr_busy_a, clr_busy_b}, 2'b11);
        rst = 1'b1; #1;
        chk("mid_rst_out", {rd_valid_a, rd_valid_b, clr_busy_a}, 3'b001);
        step();
        rst = 1'b0;
        count_sweep("rst_sweep");

        // ---- 6b: reset with a read in flight ----
        write(4'd6, 4'hF, 32'h00000077);
        rd_en = 1'b1; rd_addr = 4'd6; step(); rd_en = 1'b0;
        chk("inflight_a", {rd_valid_a, rd_data_a}, {1'b1, 32'h77});
        rst = 1'b1; #1;
        chk("inflight_rst_a", {rd_valid_a, rd_data_a}, 33'h0);
        chk("inflight_rst_b", {rd_valid_b, rd_data_b}, 33'h0);
        step();
        chk("inflight_flushed_b", {rd_valid_b, rd_data_b}, 33'h0);
        rst = 1'b0;
        count_sweep("rst2_sweep");
        chk("final_valid", {rd_valid_a, rd_valid_b}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
